// File: rtl/esc_diff_receiver.sv
// Receiver end of the differential escalation channel: decodes esc_p/esc_n, answers pings and
// escalations with the response pattern, flags integrity faults. Option: ESC_DIFF_RECEIVER_SYNC_EN.
module esc_diff_receiver #(
    parameter int CntW = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            esc_p_i,
    input  logic            esc_n_i,
    output logic            resp_p_o,
    output logic            resp_n_o,
    output logic            esc_en_o,
    output logic            sig_int_err_o,
    output logic [CntW-1:0] ping_cnt_o,
    output logic [CntW-1:0] esc_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        PING_RESP,
        ESC_RESP,
        SIGINT
    } state_e;

    logic esc_p;
    logic esc_n;

`ifdef ESC_DIFF_RECEIVER_SYNC_EN
    logic [1:0] sync_p;
    logic [1:0] sync_n;

    // Synchronizer resets to the idle level so a reset never looks like a request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_p <= 2'b00;
            sync_n <= 2'b11;
        end else begin
            sync_p <= {sync_p[0], esc_p_i};
            sync_n <= {sync_n[0], esc_n_i};
        end
    end

    assign esc_p = sync_p[1];
    assign esc_n = sync_n[1];
`else
    assign esc_p = esc_p_i;
    assign esc_n = esc_n_i;
`endif

    logic esc_lvl;
    logic idle_lvl;
    logic sigint;

    assign esc_lvl  = esc_p & ~esc_n;
    assign idle_lvl = ~esc_p & esc_n;
    assign sigint   = (esc_p == esc_n);

    state_e          state_q;
    state_e          state_d;
    logic            phase_q;
    logic [CntW-1:0] ping_cnt_q;
    logic [CntW-1:0] esc_cnt_q;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (sigint)       state_d = SIGINT;
                else if (esc_lvl) state_d = CHECK;
            end
            CHECK: begin
                if (sigint)       state_d = SIGINT;
                else if (esc_lvl) state_d = ESC_RESP;
                else              state_d = PING_RESP;
            end
            PING_RESP: begin
                if (sigint)       state_d = SIGINT;
                else if (esc_lvl) state_d = CHECK;
                else              state_d = IDLE;
            end
            ESC_RESP: begin
                if (sigint)        state_d = SIGINT;
                else if (idle_lvl) state_d = IDLE;
            end
            SIGINT: begin
                if (!sigint)      state_d = IDLE;
            end
            default:              state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            phase_q    <= 1'b0;
            ping_cnt_q <= '0;
            esc_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            // Phase restarts on every state change so both toggling patterns begin on a known value.
            phase_q <= (state_d != state_q) ? 1'b0 : ~phase_q;

            if (state_q == CHECK && state_d == PING_RESP) begin
                ping_cnt_q <= ping_cnt_q + CntW'(1);
            end

            if (state_q == CHECK && state_d == ESC_RESP) begin
                esc_cnt_q <= '0;
            end else if (state_q == ESC_RESP && esc_cnt_q != '1) begin
                esc_cnt_q <= esc_cnt_q + CntW'(1);
            end
        end
    end

    always_comb begin
        resp_p_o      = 1'b0;
        resp_n_o      = 1'b1;
        esc_en_o      = 1'b0;
        sig_int_err_o = 1'b0;
        unique case (state_q)
            CHECK: begin
                resp_p_o = 1'b1;
                resp_n_o = 1'b0;
            end
            ESC_RESP: begin
                esc_en_o = 1'b1;
                resp_p_o = phase_q;
                resp_n_o = ~phase_q;
            end
            SIGINT: begin
                // A fault is treated as escalation; equal response levels echo the fault back.
                esc_en_o      = 1'b1;
                sig_int_err_o = 1'b1;
                resp_p_o      = ~phase_q;
                resp_n_o      = ~phase_q;
            end
            default: ;
        endcase
    end

    assign ping_cnt_o = ping_cnt_q;
    assign esc_cnt_o  = esc_cnt_q;

endmodule

// File: tb/tb_esc_diff_receiver.sv
// Self-checking bench for esc_diff_receiver: directed table, hand sequences, and randomized
// stimulus against a run-length protocol model (CntW=16 and CntW=2 instances side by side).
module tb_esc_diff_receiver;

`ifdef ESC_DIFF_RECEIVER_SYNC_EN
    localparam int Lat    = 2;
    localparam bit SyncEn = 1'b1;
`else
    localparam int Lat    = 0;
    localparam bit SyncEn = 1'b0;
`endif

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic rst_i   = 1'b1;
    logic esc_p_i = 1'b0;
    logic esc_n_i = 1'b1;

    logic        rp16, rn16, en16, sig16;
    logic [15:0] ping16, esc16;
    logic        rp2, rn2, en2, sig2;
    logic [1:0]  ping2, esc2;

    esc_diff_receiver #(.CntW(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .esc_p_i(esc_p_i), .esc_n_i(esc_n_i),
        .resp_p_o(rp16), .resp_n_o(rn16), .esc_en_o(en16), .sig_int_err_o(sig16),
        .ping_cnt_o(ping16), .esc_cnt_o(esc16)
    );

    esc_diff_receiver #(.CntW(2)) dut_w2 (
        .clk_i(clk_i), .rst_i(rst_i), .esc_p_i(esc_p_i), .esc_n_i(esc_n_i),
        .resp_p_o(rp2), .resp_n_o(rn2), .esc_en_o(en2), .sig_int_err_o(sig2),
        .ping_cnt_o(ping2), .esc_cnt_o(esc2)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Protocol model: run = consecutive valid esc cycles seen, fault_age = cycles spent in a fault.
    int         run         = 0;
    int         fault_age   = -1;
    int         ping_total  = 0;
    int         esc_total   = 0;
    logic [1:0] pipe_p      = 2'b00;
    logic [1:0] pipe_n      = 2'b11;

    typedef struct {
        int r, p, n;
        int rp, rn, en, sig;
        int ping, esc;
    } vec_t;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (resp_p,resp_n,en,sig,ping,esc)", name, act, exp);
        end
    endtask

    function automatic logic [35:0] pack(input int rp, input int rn, input int en, input int sig,
                                         input int ping, input int esc);
        return {rp[0], rn[0], en[0], sig[0], ping[15:0], esc[15:0]};
    endfunction

    function automatic logic [35:0] act16();
        return {rp16, rn16, en16, sig16, ping16, esc16};
    endfunction

    function automatic logic [35:0] act2();
        return {rp2, rn2, en2, sig2, 14'd0, ping2, 14'd0, esc2};
    endfunction

    task automatic model_edge(input logic r, input logic p, input logic n);
        logic up, un;
        up = SyncEn ? pipe_p[1] : p;
        un = SyncEn ? pipe_n[1] : n;
        if (r) begin
            run = 0; fault_age = -1; ping_total = 0; esc_total = 0;
            pipe_p = 2'b00; pipe_n = 2'b11;
        end else begin
            if (fault_age < 0 && run >= 2) esc_total++;
            if (up == un) begin
                fault_age = (fault_age < 0) ? 0 : fault_age + 1;
                run = 0;
            end else if (fault_age >= 0) begin
                fault_age = -1;
                run = 0;
            end else if (up) begin
                run++;
                if (run == 2) esc_total = 0;
            end else begin
                if (run == 1) ping_total++;
                run = 0;
            end
            pipe_p = {pipe_p[0], p};
            pipe_n = {pipe_n[0], n};
        end
    endtask

    task automatic model_compare(input int cyc);
        int rp, rn, en, sig, esc_w16, esc_w2;
        rp = 0; rn = 1; en = 0; sig = 0;
        if (fault_age >= 0) begin
            rp = (fault_age % 2 == 0) ? 1 : 0; rn = rp; en = 1; sig = 1;
        end else if (run >= 2) begin
            rp = run % 2; rn = 1 - rp; en = 1;
        end else if (run == 1) begin
            rp = 1; rn = 0;
        end
        esc_w16 = (esc_total > 65535) ? 65535 : esc_total;
        esc_w2  = (esc_total > 3) ? 3 : esc_total;
        check($sformatf("model16@%0d", cyc), act16(), pack(rp, rn, en, sig, ping_total % 65536, esc_w16));
        check($sformatf("model2@%0d", cyc), act2(), pack(rp, rn, en, sig, ping_total % 4, esc_w2));
    endtask

    int cycle = 0;

    task automatic step(input logic r, input logic p, input logic n);
        rst_i = r; esc_p_i = p; esc_n_i = n;
        @(posedge clk_i);
        #1;
        cycle++;
        model_edge(r, p, n);
        model_compare(cycle);
    endtask

    task automatic reset_dut();
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        vec_t tbl[27];
        tbl = '{
            '{1,0,1, 0,1,0,0, 0,0},  // reset
            '{0,1,0, 1,0,0,0, 0,0},  // ping: CHECK
            '{0,0,1, 0,1,0,0, 1,0},  // PING_RESP
            '{0,0,1, 0,1,0,0, 1,0},
            '{0,1,0, 1,0,0,0, 1,0},  // escalation, 6 cycles
            '{0,1,0, 0,1,1,0, 1,0},
            '{0,1,0, 1,0,1,0, 1,1},
            '{0,1,0, 0,1,1,0, 1,2},
            '{0,1,0, 1,0,1,0, 1,3},
            '{0,1,0, 0,1,1,0, 1,4},
            '{0,0,1, 0,1,0,0, 1,5},
            '{0,1,1, 1,1,1,1, 1,5},  // integrity fault, 3 cycles
            '{0,1,1, 0,0,1,1, 1,5},
            '{0,1,1, 1,1,1,1, 1,5},
            '{0,0,1, 0,1,0,0, 1,5},
            '{0,1,0, 1,0,0,0, 1,5},  // back-to-back pings
            '{0,0,1, 0,1,0,0, 2,5},
            '{0,1,0, 1,0,0,0, 2,5},
            '{0,0,1, 0,1,0,0, 3,5},
            '{0,0,1, 0,1,0,0, 3,5},
            '{0,1,0, 1,0,0,0, 3,5},  // fault while in CHECK
            '{0,0,0, 1,1,1,1, 3,5},
            '{0,1,0, 0,1,0,0, 3,5},  // leaving fault goes to IDLE first
            '{0,1,0, 1,0,0,0, 3,5},
            '{0,1,0, 0,1,1,0, 3,0},
            '{0,1,1, 1,1,1,1, 3,1},  // fault preempts escalation
            '{0,0,1, 0,1,0,0, 3,1}
        };

        reset_dut();

`ifndef ESC_DIFF_RECEIVER_SYNC_EN
        foreach (tbl[i]) begin
            step(tbl[i].r[0], tbl[i].p[0], tbl[i].n[0]);
            check($sformatf("tbl[%0d]", i), act16(),
                  pack(tbl[i].rp, tbl[i].rn, tbl[i].en, tbl[i].sig, tbl[i].ping, tbl[i].esc));
        end
`else
        // Ping response shows up three cycles after the request is driven.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("sync_lat_early", act16(), pack(0, 1, 0, 0, 0, 0));
        step(1'b0, 1'b0, 1'b1);
        check("sync_lat_check", act16(), pack(1, 0, 0, 0, 0, 0));
        step(1'b0, 1'b0, 1'b1);
        check("sync_lat_ping", act16(), pack(0, 1, 0, 0, 1, 0));
`endif

        // Reset on the third ESC_RESP cycle.
        reset_dut();
        for (int i = 0; i < 4 + Lat; i++) step(1'b0, 1'b1, 1'b0);
        check("esc3_before_rst", act16(), pack(0, 1, 1, 0, 0, 2));
        step(1'b1, 1'b1, 1'b0);
        check("rst_mid_esc", act16(), pack(0, 1, 0, 0, 0, 0));

        // Counter wrap and saturation on the narrow instance.
        reset_dut();
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b1);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        check("ping_wrap_w2", act2(), {4'b0100, 14'd0, 2'd1, 16'd0});
        check("ping_cnt_w16", act16(), pack(0, 1, 0, 0, 5, 0));
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        check("esc_sat_w2", act2(), {4'b0100, 14'd0, 2'd1, 14'd0, 2'd3});
        check("esc_cnt_w16", act16(), pack(0, 1, 0, 0, 5, 5));

        // Randomized bursts of each symbol, with occasional resets.
        reset_dut();
        for (int seg = 0; seg < 900; seg++) begin
            int   sel, len;
            logic p, n, r;
            sel = $urandom_range(0, 99);
            if (sel < 45)      begin p = 1'b1; n = 1'b0; end
            else if (sel < 85) begin p = 1'b0; n = 1'b1; end
            else if (sel < 93) begin p = 1'b1; n = 1'b1; end
            else               begin p = 1'b0; n = 1'b0; end
            len = $urandom_range(1, 5);
            for (int j = 0; j < len; j++) begin
                r = ($urandom_range(0, 299) == 0);
                step(r, p, n);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
